hazard_ctl: RTL and testbench

Pipeline hazard controller for the 5-stage RV32I core. It produces the EX-stage operand forwarding selects and the load-use and branch-operand stall and bubble controls, and it handles the ID-stage redirect flush. It also sequences whole-pipeline freezes while the MEM stage waits on a slow data memory, with a bounded timeout. It sits beside the stage modules and drives only control signals; it holds no datapath values.

---
 rtl/hazard_ctl_pkg.sv | 24 ++
 rtl/hazard_ctl_if.sv | 87 ++++++++
 rtl/hazard_ctl_fwd_sel.sv | 35 +++
 rtl/hazard_ctl.sv | 172 +++++++++++++++++
 tb/tb_hazard_ctl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the RV32I pipeline hazard controller.
//   FWD_*      : operand forwarding select encodings
//   state_t    : memory-freeze sequencer states
//   cnt_width  : width of the MEM_WAIT cycle counter for a given WAIT_MAX
// -----------------------------------------------------------------------------
package hazard_pkg;

    localparam logic [1:0] FWD_NONE = 2'b00;  // operand comes from the register file
    localparam logic [1:0] FWD_MEM  = 2'b01;  // operand comes from EX/MEM
    localparam logic [1:0] FWD_WB   = 2'b10;  // operand comes from MEM/WB

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    // The counter only has to reach wait_max-1, so clog2(wait_max) bits suffice.
    function automatic int cnt_width(input int wait_max);
        return $clog2(wait_max);
    endfunction

endpackage

// File: rtl/hazard_ctl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctl_if
// Bundles every control signal between the pipeline stages and hazard_ctl.
//   master : the pipeline side (drives the i_* stage/memory status, reads o_*)
//   slave  : hazard_ctl itself (reads i_*, drives o_*)
// When HAZARD_PERF_EN is defined, the two performance counters
// o_stall_cycles and o_flush_count are added to the bundle.
// -----------------------------------------------------------------------------
interface hazard_ctl_if;

    // ID stage
    logic [4:0] i_id_rs1;
    logic [4:0] i_id_rs2;
    logic       i_id_use_rs1;
    logic       i_id_use_rs2;
    logic       i_id_is_ctrl;
    logic       i_redirect;
    // ID/EX
    logic [4:0] i_ex_rs1;
    logic [4:0] i_ex_rs2;
    logic [4:0] i_ex_rd;
    logic       i_ex_valid;
    logic       i_ex_reg_write;
    logic       i_ex_mem_read;
    // EX/MEM
    logic [4:0] i_mem_rd;
    logic       i_mem_valid;
    logic       i_mem_reg_write;
    logic       i_mem_mem_read;
    // MEM/WB
    logic [4:0] i_wb_rd;
    logic       i_wb_valid;
    logic       i_wb_reg_write;
    // data memory
    logic       i_dmem_req;
    logic       i_dmem_ready;
    // controls
    logic [1:0] o_forward_a;
    logic [1:0] o_forward_b;
    logic       o_stall_if;
    logic       o_stall_id;
    logic       o_bubble_ex;
    logic       o_stall_back;
    logic       o_flush_id;
    logic       o_dmem_timeout;
`ifdef HAZARD_PERF_EN
    logic [31:0] o_stall_cycles;
    logic [31:0] o_flush_count;

    modport master (
        output i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2, i_id_is_ctrl, i_redirect,
               i_ex_rs1, i_ex_rs2, i_ex_rd, i_ex_valid, i_ex_reg_write, i_ex_mem_read,
               i_mem_rd, i_mem_valid, i_mem_reg_write, i_mem_mem_read,
               i_wb_rd, i_wb_valid, i_wb_reg_write, i_dmem_req, i_dmem_ready,
        input  o_forward_a, o_forward_b, o_stall_if, o_stall_id, o_bubble_ex,
               o_stall_back, o_flush_id, o_dmem_timeout, o_stall_cycles, o_flush_count
    );

    modport slave (
        input  i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2, i_id_is_ctrl, i_redirect,
               i_ex_rs1, i_ex_rs2, i_ex_rd, i_ex_valid, i_ex_reg_write, i_ex_mem_read,
               i_mem_rd, i_mem_valid, i_mem_reg_write, i_mem_mem_read,
               i_wb_rd, i_wb_valid, i_wb_reg_write, i_dmem_req, i_dmem_ready,
        output o_forward_a, o_forward_b, o_stall_if, o_stall_id, o_bubble_ex,
               o_stall_back, o_flush_id, o_dmem_timeout, o_stall_cycles, o_flush_count
    );
`else
    modport master (
        output i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2, i_id_is_ctrl, i_redirect,
               i_ex_rs1, i_ex_rs2, i_ex_rd, i_ex_valid, i_ex_reg_write, i_ex_mem_read,
               i_mem_rd, i_mem_valid, i_mem_reg_write, i_mem_mem_read,
               i_wb_rd, i_wb_valid, i_wb_reg_write, i_dmem_req, i_dmem_ready,
        input  o_forward_a, o_forward_b, o_stall_if, o_stall_id, o_bubble_ex,
               o_stall_back, o_flush_id, o_dmem_timeout
    );

    modport slave (
        input  i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2, i_id_is_ctrl, i_redirect,
               i_ex_rs1, i_ex_rs2, i_ex_rd, i_ex_valid, i_ex_reg_write, i_ex_mem_read,
               i_mem_rd, i_mem_valid, i_mem_reg_write, i_mem_mem_read,
               i_wb_rd, i_wb_valid, i_wb_reg_write, i_dmem_req, i_dmem_ready,
        output o_forward_a, o_forward_b, o_stall_if, o_stall_id, o_bubble_ex,
               o_stall_back, o_flush_id, o_dmem_timeout
    );
`endif

endinterface

// File: rtl/hazard_ctl_fwd_sel.sv
// -----------------------------------------------------------------------------
// fwd_sel
// Forwarding select for one EX-stage source operand.
//   ex_rs                          : EX source register address
//   mem_valid/mem_reg_write/mem_rd : EX/MEM writer
//   wb_valid/wb_reg_write/wb_rd    : MEM/WB writer
//   sel                            : FWD_NONE / FWD_MEM / FWD_WB
// The younger EX/MEM result wins over MEM/WB; x0 is never forwarded.
// -----------------------------------------------------------------------------
module fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] ex_rs,
    input  logic       mem_valid,
    input  logic       mem_reg_write,
    input  logic [4:0] mem_rd,
    input  logic       wb_valid,
    input  logic       wb_reg_write,
    input  logic [4:0] wb_rd,
    output logic [1:0] sel
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = mem_valid && mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ex_rs);
    assign wb_hit  = wb_valid  && wb_reg_write  && (wb_rd  != 5'd0) && (wb_rd  == ex_rs);

    always_comb begin
        if (mem_hit)     sel = FWD_MEM;
        else if (wb_hit) sel = FWD_WB;
        else             sel = FWD_NONE;
    end

endmodule

// File: rtl/hazard_ctl.sv
// -----------------------------------------------------------------------------
// hazard_ctl
// Pipeline hazard controller for the 5-stage RV32I core: EX operand
// forwarding, load-use and branch-operand stalls, ID redirect flush, and a
// whole-pipeline freeze while the data memory is not ready (with timeout).
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : hazard_ctl_if.slave -- stage status in, stall/flush/forward out
// Parameters:
//   WAIT_MAX : MEM_WAIT cycles tolerated before the wait is abandoned (2..65535)
// Configuration:
//   HAZARD_PERF_EN : adds saturating o_stall_cycles / o_flush_count counters
// -----------------------------------------------------------------------------
module hazard_ctl
    import hazard_pkg::*;
#(
    parameter int WAIT_MAX = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    hazard_ctl_if.slave  bus
);

    localparam int CW = cnt_width(WAIT_MAX);
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          redirect_pending, redirect_pending_d;

    logic used_rs1, used_rs2;
    logic load_use, ctrl_haz;
    logic ex_hit, mem_hit;

    logic stall_if, stall_id, bubble_ex, stall_back, flush_id, dmem_timeout;

    // ---------------- forwarding ----------------
    fwd_sel u_fwd_a (
        .ex_rs         (bus.i_ex_rs1),
        .mem_valid     (bus.i_mem_valid),
        .mem_reg_write (bus.i_mem_reg_write),
        .mem_rd        (bus.i_mem_rd),
        .wb_valid      (bus.i_wb_valid),
        .wb_reg_write  (bus.i_wb_reg_write),
        .wb_rd         (bus.i_wb_rd),
        .sel           (bus.o_forward_a)
    );

    fwd_sel u_fwd_b (
        .ex_rs         (bus.i_ex_rs2),
        .mem_valid     (bus.i_mem_valid),
        .mem_reg_write (bus.i_mem_reg_write),
        .mem_rd        (bus.i_mem_rd),
        .wb_valid      (bus.i_wb_valid),
        .wb_reg_write  (bus.i_wb_reg_write),
        .wb_rd         (bus.i_wb_rd),
        .sel           (bus.o_forward_b)
    );

    // ---------------- hazard terms ----------------
    // A non-zero "used" source guarantees a rd match implies rd != x0.
    assign used_rs1 = bus.i_id_use_rs1 && (bus.i_id_rs1 != 5'd0);
    assign used_rs2 = bus.i_id_use_rs2 && (bus.i_id_rs2 != 5'd0);

    assign ex_hit  = (used_rs1 && (bus.i_ex_rd  == bus.i_id_rs1)) ||
                     (used_rs2 && (bus.i_ex_rd  == bus.i_id_rs2));
    assign mem_hit = (used_rs1 && (bus.i_mem_rd == bus.i_id_rs1)) ||
                     (used_rs2 && (bus.i_mem_rd == bus.i_id_rs2));

    assign load_use = bus.i_ex_valid && bus.i_ex_mem_read && ex_hit;

    // Branches resolve in ID, so they also wait for ALU results still in EX
    // and for loads that have only reached MEM.
    assign ctrl_haz = bus.i_id_is_ctrl &&
                      ((bus.i_ex_valid  && bus.i_ex_reg_write  && ex_hit) ||
                       (bus.i_mem_valid && bus.i_mem_mem_read && mem_hit));

    // ---------------- sequencer ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state            <= ST_RUN;
            cnt              <= '0;
            redirect_pending <= 1'b0;
        end else begin
            state            <= state_d;
            cnt              <= cnt_d;
            redirect_pending <= redirect_pending_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can infer a latch.
        state_d            = state;
        cnt_d              = cnt;
        redirect_pending_d = redirect_pending;
        stall_if           = 1'b0;
        stall_id           = 1'b0;
        bubble_ex          = 1'b0;
        stall_back         = 1'b0;
        flush_id           = 1'b0;
        dmem_timeout       = 1'b0;

        case (state)
            ST_RUN: begin
                if (bus.i_dmem_req && !bus.i_dmem_ready) begin
                    stall_if   = 1'b1;
                    stall_id   = 1'b1;
                    stall_back = 1'b1;
                    cnt_d      = '0;
                    state_d    = ST_MEM_WAIT;
                end else if (load_use || ctrl_haz) begin
                    // The redirect is recomputed once the operand arrives,
                    // so no flush while the ID instruction is held.
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    bubble_ex = 1'b1;
                end else begin
                    flush_id           = bus.i_redirect || redirect_pending;
                    redirect_pending_d = 1'b0;
                end
            end

            ST_MEM_WAIT: begin
                stall_if   = 1'b1;
                stall_id   = 1'b1;
                stall_back = 1'b1;
                if (bus.i_redirect) redirect_pending_d = 1'b1;
                if (bus.i_dmem_ready) begin
                    state_d = ST_RUN;
                end else if (cnt == CNT_LAST) begin
                    dmem_timeout = 1'b1;
                    state_d      = ST_RUN;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end

            default: state_d = ST_RUN;
        endcase
    end

    assign bus.o_stall_if     = stall_if;
    assign bus.o_stall_id     = stall_id;
    assign bus.o_bubble_ex    = bubble_ex;
    assign bus.o_stall_back   = stall_back;
    assign bus.o_flush_id     = flush_id;
    assign bus.o_dmem_timeout = dmem_timeout;

`ifdef HAZARD_PERF_EN
    // ---------------- performance counters ----------------
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall_if && (stall_cycles != 32'hFFFF_FFFF)) stall_cycles <= stall_cycles + 32'd1;
            if (flush_id && (flush_count  != 32'hFFFF_FFFF)) flush_count  <= flush_count  + 32'd1;
        end
    end

    assign bus.o_stall_cycles = stall_cycles;
    assign bus.o_flush_count  = flush_count;
`endif

endmodule

// File: tb/tb_hazard_ctl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctl
// Directed bench for hazard_ctl built with WAIT_MAX = 4. Inputs change 1 ns
// after the rising edge; outputs are compared 1 ns later, well before the
// next edge. Define HAZARD_PERF_EN to include the counter checks.
// -----------------------------------------------------------------------------
module tb_hazard_ctl;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    hazard_ctl_if bus ();

    hazard_ctl #(.WAIT_MAX(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic idle();
        bus.i_id_rs1 = '0;        bus.i_id_rs2 = '0;
        bus.i_id_use_rs1 = 1'b0;  bus.i_id_use_rs2 = 1'b0;
        bus.i_id_is_ctrl = 1'b0;  bus.i_redirect = 1'b0;
        bus.i_ex_rs1 = '0;        bus.i_ex_rs2 = '0;       bus.i_ex_rd = '0;
        bus.i_ex_valid = 1'b0;    bus.i_ex_reg_write = 1'b0; bus.i_ex_mem_read = 1'b0;
        bus.i_mem_rd = '0;        bus.i_mem_valid = 1'b0;
        bus.i_mem_reg_write = 1'b0; bus.i_mem_mem_read = 1'b0;
        bus.i_wb_rd = '0;         bus.i_wb_valid = 1'b0;   bus.i_wb_reg_write = 1'b0;
        bus.i_dmem_req = 1'b0;    bus.i_dmem_ready = 1'b0;
    endtask

    // Advance to just after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        idle();

        // ---------------- reset state ----------------
        #2;
        check("rst_fwd_a",   32'(bus.o_forward_a),    32'd0);
        check("rst_fwd_b",   32'(bus.o_forward_b),    32'd0);
        check("rst_stall_if", 32'(bus.o_stall_if),    32'd0);
        check("rst_stall_back", 32'(bus.o_stall_back), 32'd0);
        check("rst_bubble",  32'(bus.o_bubble_ex),    32'd0);
        check("rst_flush",   32'(bus.o_flush_id),     32'd0);
        check("rst_timeout", 32'(bus.o_dmem_timeout), 32'd0);
        #10 rst_n = 1'b1;

        // ---------------- forwarding priority ----------------
        next_cycle();
        bus.i_ex_rs1 = 5'd5;
        bus.i_mem_valid = 1'b1; bus.i_mem_reg_write = 1'b1; bus.i_mem_rd = 5'd5;
        bus.i_wb_valid  = 1'b1; bus.i_wb_reg_write  = 1'b1; bus.i_wb_rd  = 5'd5;
        #1;
        check("fwd_a_mem_wins", 32'(bus.o_forward_a), 32'd1);
        check("fwd_b_none",     32'(bus.o_forward_b), 32'd0);
        bus.i_mem_reg_write = 1'b0;
        #1;
        check("fwd_a_wb", 32'(bus.o_forward_a), 32'd2);
        bus.i_mem_reg_write = 1'b1; bus.i_mem_rd = 5'd0; bus.i_wb_rd = 5'd0; bus.i_ex_rs1 = 5'd0;
        #1;
        check("fwd_a_x0", 32'(bus.o_forward_a), 32'd0);
        bus.i_ex_rs2 = 5'd12; bus.i_wb_rd = 5'd12;
        bus.i_mem_valid = 1'b0; bus.i_mem_rd = 5'd12;
        #1;
        check("fwd_b_wb_mem_invalid", 32'(bus.o_forward_b), 32'd2);

        // ---------------- load-use ----------------
        next_cycle();
        idle();
        bus.i_ex_valid = 1'b1; bus.i_ex_mem_read = 1'b1; bus.i_ex_reg_write = 1'b1; bus.i_ex_rd = 5'd3;
        bus.i_id_rs2 = 5'd3; bus.i_id_use_rs2 = 1'b1;
        bus.i_redirect = 1'b1;
        #1;
        check("lu_stall_if",  32'(bus.o_stall_if),   32'd1);
        check("lu_stall_id",  32'(bus.o_stall_id),   32'd1);
        check("lu_bubble",    32'(bus.o_bubble_ex),  32'd1);
        check("lu_no_back",   32'(bus.o_stall_back), 32'd0);
        check("lu_no_flush",  32'(bus.o_flush_id),   32'd0);
        next_cycle();
        bus.i_ex_valid = 1'b0;          // bubble now sits in EX
        #1;
        check("lu_released",  32'(bus.o_stall_if),   32'd0);
        check("lu_flush_after", 32'(bus.o_flush_id), 32'd1);
        next_cycle();
        bus.i_redirect = 1'b0;
        bus.i_ex_valid = 1'b1; bus.i_id_use_rs2 = 1'b0;
        #1;
        check("lu_unused_src", 32'(bus.o_stall_if), 32'd0);

        // ---------------- branch on load: 2 stall cycles ----------------
        next_cycle();
        idle();
        bus.i_id_is_ctrl = 1'b1; bus.i_id_rs1 = 5'd7; bus.i_id_use_rs1 = 1'b1;
        bus.i_ex_valid = 1'b1; bus.i_ex_mem_read = 1'b1; bus.i_ex_reg_write = 1'b1; bus.i_ex_rd = 5'd7;
        bus.i_redirect = 1'b1;
        #1;
        check("brld_c1_stall", 32'(bus.o_stall_if), 32'd1);
        check("brld_c1_flush", 32'(bus.o_flush_id), 32'd0);
        next_cycle();
        bus.i_ex_valid = 1'b0; bus.i_ex_mem_read = 1'b0; bus.i_ex_reg_write = 1'b0;
        bus.i_mem_valid = 1'b1; bus.i_mem_mem_read = 1'b1; bus.i_mem_reg_write = 1'b1; bus.i_mem_rd = 5'd7;
        #1;
        check("brld_c2_stall",  32'(bus.o_stall_if),  32'd1);
        check("brld_c2_bubble", 32'(bus.o_bubble_ex), 32'd1);
        check("brld_c2_flush",  32'(bus.o_flush_id),  32'd0);
        next_cycle();
        bus.i_mem_valid = 1'b0;
        bus.i_wb_valid = 1'b1; bus.i_wb_reg_write = 1'b1; bus.i_wb_rd = 5'd7;
        #1;
        check("brld_c3_stall", 32'(bus.o_stall_if), 32'd0);
        check("brld_c3_flush", 32'(bus.o_flush_id), 32'd1);

        // ---------------- branch on ALU result: 1 stall cycle ----------------
        next_cycle();
        idle();
        bus.i_id_is_ctrl = 1'b1; bus.i_id_rs2 = 5'd9; bus.i_id_use_rs2 = 1'b1;
        bus.i_ex_valid = 1'b1; bus.i_ex_reg_write = 1'b1; bus.i_ex_rd = 5'd9;
        #1;
        check("bralu_c1_stall", 32'(bus.o_stall_if), 32'd1);
        next_cycle();
        bus.i_ex_valid = 1'b0;
        bus.i_mem_valid = 1'b1; bus.i_mem_reg_write = 1'b1; bus.i_mem_rd = 5'd9;
        #1;
        check("bralu_c2_stall", 32'(bus.o_stall_if), 32'd0);

        // ---------------- memory wait, ready after 3 cycles ----------------
        next_cycle();
        idle();
        // A pending load-use is present throughout; the freeze must outrank it.
        bus.i_ex_valid = 1'b1; bus.i_ex_mem_read = 1'b1; bus.i_ex_rd = 5'd4;
        bus.i_id_rs1 = 5'd4; bus.i_id_use_rs1 = 1'b1;
        bus.i_dmem_req = 1'b1;
        #1;
        check("mw_c1_back",   32'(bus.o_stall_back), 32'd1);
        check("mw_c1_if",     32'(bus.o_stall_if),   32'd1);
        check("mw_c1_bubble", 32'(bus.o_bubble_ex),  32'd0);
        next_cycle();
        bus.i_redirect = 1'b1;
        #1;
        check("mw_c2_back",  32'(bus.o_stall_back), 32'd1);
        check("mw_c2_flush", 32'(bus.o_flush_id),   32'd0);
        next_cycle();
        bus.i_redirect = 1'b0;
        #1;
        check("mw_c3_back", 32'(bus.o_stall_back), 32'd1);
        next_cycle();
        bus.i_dmem_ready = 1'b1;
        #1;
        check("mw_c4_back",    32'(bus.o_stall_back),   32'd1);
        check("mw_c4_bubble",  32'(bus.o_bubble_ex),    32'd0);
        check("mw_c4_timeout", 32'(bus.o_dmem_timeout), 32'd0);
        next_cycle();
        idle();
        #1;
        check("mw_c5_back",  32'(bus.o_stall_back), 32'd0);
        check("mw_c5_flush", 32'(bus.o_flush_id),   32'd1);
        next_cycle();
        #1;
        check("mw_c6_flush", 32'(bus.o_flush_id), 32'd0);

        // ---------------- ready with the request: no stall ----------------
        next_cycle();
        bus.i_dmem_req = 1'b1; bus.i_dmem_ready = 1'b1;
        #1;
        check("mw_ready_now", 32'(bus.o_stall_back), 32'd0);

        // ---------------- reset in the middle of a wait ----------------
        next_cycle();
        bus.i_dmem_ready = 1'b0;
        next_cycle();                    // second freeze cycle, in MEM_WAIT
        #1;
        check("rw_in_wait", 32'(bus.o_stall_back), 32'd1);
        rst_n = 1'b0;
        bus.i_dmem_req = 1'b0;
        #1;
        check("rw_async_if",   32'(bus.o_stall_if),     32'd0);
        check("rw_async_back", 32'(bus.o_stall_back),   32'd0);
        check("rw_async_to",   32'(bus.o_dmem_timeout), 32'd0);
`ifdef HAZARD_PERF_EN
        check("rw_perf_stall", bus.o_stall_cycles, 32'd0);
        check("rw_perf_flush", bus.o_flush_count,  32'd0);
`endif
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            #1;
            check("rw_no_timeout", 32'(bus.o_dmem_timeout), 32'd0);
        end
        rst_n = 1'b1;

        // ---------------- timeout, WAIT_MAX = 4 ----------------
        next_cycle();
        bus.i_dmem_req = 1'b1; bus.i_dmem_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            #1;
            check($sformatf("to_c%0d_back", i), 32'(bus.o_stall_back), 32'd1);
            check($sformatf("to_c%0d_pulse", i), 32'(bus.o_dmem_timeout), (i == 5) ? 32'd1 : 32'd0);
            next_cycle();
        end
        bus.i_dmem_req = 1'b0;
        #1;
        check("to_back_run",  32'(bus.o_stall_back),   32'd0);
        check("to_pulse_off", 32'(bus.o_dmem_timeout), 32'd0);
`ifdef HAZARD_PERF_EN
        check("perf_stall_5", bus.o_stall_cycles, 32'd5);
        check("perf_flush_0", bus.o_flush_count,  32'd0);
        next_cycle();
        bus.i_redirect = 1'b1;
        next_cycle();
        bus.i_redirect = 1'b0;
        #1;
        check("perf_flush_1", bus.o_flush_count,  32'd1);
        check("perf_stall_k", bus.o_stall_cycles, 32'd5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
